mac_tbl_responder: RTL and testbench

- Responder side of the lookup manager's table request interface. It holds the hash-indexed MAC forwarding table.
- Per request it returns a DMAC lookup result (port, hit, or clash) and performs SMAC learning/refresh.
- An incremental aging sweep invalidates stale entries.
- Sits between the lookup manager (requests in, results out) and nothing downstream; entries are stored in flop registers.

---
 rtl/mac_tbl_responder_pkg.sv | 24 ++
 rtl/mac_tbl_ager.sv | 59 +++++
 rtl/mac_tbl_responder.sv | 213 +++++++++++++++++++++
 tb/tb_mac_tbl_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_tbl_responder_pkg.sv
// Shared definitions for the MAC table responder: entry field widths, FSM encodings, helpers.
package mac_tbl_responder_pkg;

    localparam int MAC_W     = 48;
    localparam int VLAN_W    = 12;
    localparam int AGE_W     = 2;
    localparam int MCAST_BIT = 40;

    localparam logic [AGE_W-1:0] AGE_MAX_DEF = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Group (multicast/broadcast) addresses carry the I/G bit in the first octet.
    function automatic logic is_group_mac(input logic [MAC_W-1:0] mac);
        return mac[MCAST_BIT];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/mac_tbl_ager.sv
// Aging tick timer and sweep pointer; one table entry is offered per cycle unless a learn write stalls it.
module mac_tbl_ager
    import mac_tbl_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 6,
    parameter logic [31:0] AGE_TICK_CYC = 32'd1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  stall,
    output logic                  step,
    output logic [ADDR_WIDTH-1:0] sweep_ptr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

    logic [31:0]           timer_r;
    logic                  tick_s;
    logic                  sweep_act_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic                  step_s;

    assign tick_s    = (timer_r == (AGE_TICK_CYC - 32'd1));
    assign step_s    = sweep_act_r & ~stall;
    assign step      = step_s;
    assign sweep_ptr = ptr_r;

    // Free-running tick timer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            timer_r <= 32'd0;
        end else if (tick_s) begin
            timer_r <= 32'd0;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Sweep control; a tick seen while a sweep is running is dropped.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sweep_act_r <= 1'b0;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
        end else if (sweep_act_r) begin
            if (step_s) begin
                if (ptr_r == PTR_LAST) begin
                    sweep_act_r <= 1'b0;
                    ptr_r       <= {ADDR_WIDTH{1'b0}};
                end else begin
                    ptr_r <= ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end else if (tick_s) begin
            sweep_act_r <= 1'b1;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/mac_tbl_responder.sv
// Table-request responder: DMAC lookup and SMAC learn/refresh against a flop-based,
// hash-indexed MAC table that is aged by mac_tbl_ager.
module mac_tbl_responder
    import mac_tbl_responder_pkg::*;
#(
    parameter int               HASH_DATA_WIDTH = 12,
    parameter int               PORT_NUM        = 4,
    parameter int               ADDR_WIDTH      = 6,
    parameter logic [31:0]      AGE_TICK_CYC    = 32'd1000000,
    parameter logic [AGE_W-1:0] AGE_MAX         = AGE_MAX_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [VLAN_W-1:0]          i_vlan_id,
    input  logic [HASH_DATA_WIDTH-1:0] i_dmac_addr,
    input  logic                       i_dmac_addr_vld,
    input  logic [MAC_W-1:0]           i_dmac,
    input  logic [HASH_DATA_WIDTH-1:0] i_smac_addr,
    input  logic                       i_smac_addr_vld,
    input  logic [MAC_W-1:0]           i_smac,
    input  logic [PORT_NUM-1:0]        i_mac_rx_port,
    output logic [PORT_NUM-1:0]        o_dmac_tx_port_rslt,
    output logic                       o_dmac_lookup_vld,
    output logic                       o_dmac_lookup_clash,
    output logic [PORT_NUM-1:0]        o_smac_tx_port_rslt,
    output logic                       o_smac_tx_port_vld,
    output logic                       o_busy,
    output logic [15:0]                o_drop_cnt,
    output logic [15:0]                o_learn_clash_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PORT_NUM-1:0] PORT_ZERO = {PORT_NUM{1'b0}};

    logic                tbl_valid_r [DEPTH];
    logic [MAC_W-1:0]    tbl_mac_r   [DEPTH];
    logic [VLAN_W-1:0]   tbl_vlan_r  [DEPTH];
    logic [PORT_NUM-1:0] tbl_port_r  [DEPTH];
    logic [AGE_W-1:0]    tbl_age_r   [DEPTH];

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic                  req_s;
    logic [ADDR_WIDTH-1:0] dkey_r;
    logic [ADDR_WIDTH-1:0] skey_r;
    logic [VLAN_W-1:0]     vlan_r;
    logic [MAC_W-1:0]      dmac_r;
    logic [MAC_W-1:0]      smac_r;
    logic [PORT_NUM-1:0]   rx_port_r;
    logic                  dvld_r;
    logic                  svld_r;

    logic                  d_valid_s;
    logic                  d_match_s;
    logic                  s_valid_s;
    logic                  s_match_s;
    logic                  s_group_s;
    logic                  learn_wr_r;
    logic                  learn_clash_r;
    logic                  learn_we_s;
    logic                  age_step_s;
    logic [ADDR_WIDTH-1:0] age_ptr_s;
    logic                  unused_key_bits_s;

    // Only the low key bits index the table.
    assign unused_key_bits_s = ^{i_dmac_addr[HASH_DATA_WIDTH-1:ADDR_WIDTH],
                                 i_smac_addr[HASH_DATA_WIDTH-1:ADDR_WIDTH]};

    assign req_s      = i_dmac_addr_vld | i_smac_addr_vld;
    assign d_valid_s  = tbl_valid_r[dkey_r];
    assign d_match_s  = d_valid_s && (tbl_mac_r[dkey_r] == dmac_r) && (tbl_vlan_r[dkey_r] == vlan_r);
    assign s_valid_s  = tbl_valid_r[skey_r];
    assign s_match_s  = s_valid_s && (tbl_mac_r[skey_r] == smac_r) && (tbl_vlan_r[skey_r] == vlan_r);
    assign s_group_s  = is_group_mac(smac_r);
    assign learn_we_s = (state_r == ST_RESP) && learn_wr_r;

    // Next-state decode for the IDLE -> LOOKUP -> RESP request pipeline.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            o_busy  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Request capture, only when idle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dkey_r    <= {ADDR_WIDTH{1'b0}};
            skey_r    <= {ADDR_WIDTH{1'b0}};
            vlan_r    <= {VLAN_W{1'b0}};
            dmac_r    <= {MAC_W{1'b0}};
            smac_r    <= {MAC_W{1'b0}};
            rx_port_r <= PORT_ZERO;
            dvld_r    <= 1'b0;
            svld_r    <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            dkey_r    <= i_dmac_addr[ADDR_WIDTH-1:0];
            skey_r    <= i_smac_addr[ADDR_WIDTH-1:0];
            vlan_r    <= i_vlan_id;
            dmac_r    <= i_dmac;
            smac_r    <= i_smac;
            rx_port_r <= i_mac_rx_port;
            dvld_r    <= i_dmac_addr_vld;
            svld_r    <= i_smac_addr_vld;
        end
    end

    // Compare in LOOKUP, present results during RESP; the learn write lands at the end of RESP.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_dmac_lookup_vld   <= 1'b0;
            o_dmac_tx_port_rslt <= PORT_ZERO;
            o_dmac_lookup_clash <= 1'b0;
            o_smac_tx_port_vld  <= 1'b0;
            o_smac_tx_port_rslt <= PORT_ZERO;
            learn_wr_r          <= 1'b0;
            learn_clash_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_LOOKUP: begin
                    o_dmac_lookup_vld   <= dvld_r;
                    o_dmac_tx_port_rslt <= (dvld_r && d_match_s) ? tbl_port_r[dkey_r] : PORT_ZERO;
                    o_dmac_lookup_clash <= dvld_r && d_valid_s && !d_match_s;
                    o_smac_tx_port_vld  <= svld_r;
                    o_smac_tx_port_rslt <= (svld_r && !s_group_s && s_match_s) ? tbl_port_r[skey_r] : PORT_ZERO;
                    learn_wr_r          <= svld_r && !s_group_s && !(s_valid_s && !s_match_s);
                    learn_clash_r       <= svld_r && !s_group_s && s_valid_s && !s_match_s;
                end
                default: begin
                    o_dmac_lookup_vld   <= 1'b0;
                    o_dmac_tx_port_rslt <= PORT_ZERO;
                    o_dmac_lookup_clash <= 1'b0;
                    o_smac_tx_port_vld  <= 1'b0;
                    o_smac_tx_port_rslt <= PORT_ZERO;
                    learn_wr_r          <= 1'b0;
                    learn_clash_r       <= 1'b0;
                end
            endcase
        end
    end

    // Saturating drop and learn-clash counters.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_drop_cnt        <= 16'd0;
            o_learn_clash_cnt <= 16'd0;
        end else begin
            if ((state_r != ST_IDLE) && req_s) begin
                o_drop_cnt <= sat_inc16(o_drop_cnt);
            end
            if ((state_r == ST_RESP) && learn_clash_r) begin
                o_learn_clash_cnt <= sat_inc16(o_learn_clash_cnt);
            end
        end
    end

    // Table storage: learn write has priority, the aging step is stalled in that cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_valid_r[i] <= 1'b0;
                tbl_mac_r[i]   <= {MAC_W{1'b0}};
                tbl_vlan_r[i]  <= {VLAN_W{1'b0}};
                tbl_port_r[i]  <= PORT_ZERO;
                tbl_age_r[i]   <= {AGE_W{1'b0}};
            end
        end else if (learn_we_s) begin
            tbl_valid_r[skey_r] <= 1'b1;
            tbl_mac_r[skey_r]   <= smac_r;
            tbl_vlan_r[skey_r]  <= vlan_r;
            tbl_port_r[skey_r]  <= rx_port_r;
            tbl_age_r[skey_r]   <= AGE_MAX;
        end else if (age_step_s && tbl_valid_r[age_ptr_s]) begin
            if (tbl_age_r[age_ptr_s] == {AGE_W{1'b0}}) begin
                tbl_valid_r[age_ptr_s] <= 1'b0;
            end else begin
                tbl_age_r[age_ptr_s] <= tbl_age_r[age_ptr_s] - 2'd1;
            end
        end
    end

    mac_tbl_ager #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .AGE_TICK_CYC (AGE_TICK_CYC)
    ) u_ager (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .stall     (learn_we_s),
        .step      (age_step_s),
        .sweep_ptr (age_ptr_s)
    );

endmodule

// File: tb/tb_mac_tbl_responder.sv
// Directed bench for mac_tbl_responder: lookup/learn/clash/refresh, drop pacing, aging and reset.
module tb_mac_tbl_responder;

    localparam logic [47:0] MAC_A = 48'hAA0000000001;
    localparam logic [47:0] MAC_B = 48'h001122334455;
    localparam logic [47:0] MAC_C = 48'h020000000007;
    localparam logic [47:0] MAC_M = 48'h01005E000001;
    localparam logic [47:0] MAC_G = 48'h02000000000A;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [11:0] i_vlan_id = 12'd0;
    logic [11:0] i_dmac_addr = 12'd0;
    logic        i_dmac_addr_vld = 1'b0;
    logic [47:0] i_dmac = 48'd0;
    logic [11:0] i_smac_addr = 12'd0;
    logic        i_smac_addr_vld = 1'b0;
    logic [47:0] i_smac = 48'd0;
    logic [3:0]  i_mac_rx_port = 4'd0;
    logic [3:0]  o_dmac_tx_port_rslt;
    logic        o_dmac_lookup_vld;
    logic        o_dmac_lookup_clash;
    logic [3:0]  o_smac_tx_port_rslt;
    logic        o_smac_tx_port_vld;
    logic        o_busy;
    logic [15:0] o_drop_cnt;
    logic [15:0] o_learn_clash_cnt;

    int n_chk = 0;
    int n_err = 0;

    mac_tbl_responder #(
        .HASH_DATA_WIDTH (12),
        .PORT_NUM        (4),
        .ADDR_WIDTH      (6),
        .AGE_TICK_CYC    (32'd100),
        .AGE_MAX         (2'd3)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_vlan_id           (i_vlan_id),
        .i_dmac_addr         (i_dmac_addr),
        .i_dmac_addr_vld     (i_dmac_addr_vld),
        .i_dmac              (i_dmac),
        .i_smac_addr         (i_smac_addr),
        .i_smac_addr_vld     (i_smac_addr_vld),
        .i_smac              (i_smac),
        .i_mac_rx_port       (i_mac_rx_port),
        .o_dmac_tx_port_rslt (o_dmac_tx_port_rslt),
        .o_dmac_lookup_vld   (o_dmac_lookup_vld),
        .o_dmac_lookup_clash (o_dmac_lookup_clash),
        .o_smac_tx_port_rslt (o_smac_tx_port_rslt),
        .o_smac_tx_port_vld  (o_smac_tx_port_vld),
        .o_busy              (o_busy),
        .o_drop_cnt          (o_drop_cnt),
        .o_learn_clash_cnt   (o_learn_clash_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [11:0] dkey, input logic [47:0] dmac,
                         input logic sv, input logic [11:0] skey, input logic [47:0] smac,
                         input logic [11:0] vlan, input logic [3:0] port);
        i_dmac_addr_vld = dv;
        i_dmac_addr     = dkey;
        i_dmac          = dmac;
        i_smac_addr_vld = sv;
        i_smac_addr     = skey;
        i_smac          = smac;
        i_vlan_id       = vlan;
        i_mac_rx_port   = port;
    endtask

    task automatic idle_in();
        i_dmac_addr_vld = 1'b0;
        i_smac_addr_vld = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_dvld0"}, 48'(o_dmac_lookup_vld), 48'(1'b0));
        check_val({tag, "_svld0"}, 48'(o_smac_tx_port_vld), 48'(1'b0));
    endtask

    // One request, results checked exactly two cycles after the request cycle.
    task automatic req_chk(input string tag,
                           input logic dv, input logic [11:0] dkey, input logic [47:0] dmac,
                           input logic sv, input logic [11:0] skey, input logic [47:0] smac,
                           input logic [11:0] vlan, input logic [3:0] port,
                           input logic e_dv, input logic [3:0] e_dr, input logic e_cl,
                           input logic e_sv, input logic [3:0] e_sr);
        @(negedge i_clk);
        drive(dv, dkey, dmac, sv, skey, smac, vlan, port);
        @(negedge i_clk);
        idle_in();
        check_quiet({tag, "_early"});
        check_val({tag, "_busy"}, 48'(o_busy), 48'(1'b1));
        @(negedge i_clk);
        check_val({tag, "_dvld"},  48'(o_dmac_lookup_vld),   48'(e_dv));
        check_val({tag, "_drslt"}, 48'(o_dmac_tx_port_rslt), 48'(e_dr));
        check_val({tag, "_clash"}, 48'(o_dmac_lookup_clash), 48'(e_cl));
        check_val({tag, "_svld"},  48'(o_smac_tx_port_vld),  48'(e_sv));
        check_val({tag, "_srslt"}, 48'(o_smac_tx_port_rslt), 48'(e_sr));
        @(negedge i_clk);
        check_quiet({tag, "_late"});
        check_val({tag, "_idle"}, 48'(o_busy), 48'(1'b0));
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check_quiet("rst");
        check_val("rst_drslt", 48'(o_dmac_tx_port_rslt), 48'h0);
        check_val("rst_clash", 48'(o_dmac_lookup_clash), 48'h0);
        check_val("rst_srslt", 48'(o_smac_tx_port_rslt), 48'h0);
        check_val("rst_busy",  48'(o_busy), 48'h0);
        check_val("rst_drop",  48'(o_drop_cnt), 48'h0);
        check_val("rst_lclash", 48'(o_learn_clash_cnt), 48'h0);
        i_rst = 1'b1;

        // Empty table miss, then learn and hit.
        req_chk("miss",   1'b1, 12'h005, MAC_B, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
        req_chk("learn",  1'b0, 12'h000, 48'h0, 1'b1, 12'h005, MAC_A, 12'd1, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000);
        req_chk("hit",    1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000);

        // Same index, different MAC: lookup clash and refused learn.
        req_chk("dclash", 1'b1, 12'h045, MAC_B, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
        req_chk("lclash", 1'b0, 12'h000, 48'h0, 1'b1, 12'h045, MAC_B, 12'd1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000);
        check_val("lclash_cnt", 48'(o_learn_clash_cnt), 48'd1);
        req_chk("unchg",  1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000);

        // Station move refreshes port; VLAN mismatch is a clash.
        req_chk("move",   1'b0, 12'h000, 48'h0, 1'b1, 12'h005, MAC_A, 12'd1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0010);
        req_chk("moved",  1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000);
        req_chk("vlanx",  1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd2, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);

        // Multicast source is never learned.
        req_chk("mcast",  1'b0, 12'h000, 48'h0, 1'b1, 12'h009, MAC_M, 12'd1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000);
        req_chk("mcmiss", 1'b1, 12'h009, MAC_M, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
        check_val("mc_lclash_cnt", 48'(o_learn_clash_cnt), 48'd1);

        // Combined request on one index: DMAC sees the table before the learn.
        req_chk("both",   1'b1, 12'h007, MAC_C, 1'b1, 12'h007, MAC_C, 12'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000);
        req_chk("bothhit",1'b1, 12'h007, MAC_C, 1'b0, 12'h000, 48'h0, 12'd3, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000);

        // Back-to-back strobes: second dropped, a request three cycles later accepted.
        @(negedge i_clk);
        drive(1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000);
        @(negedge i_clk);
        check_val("b2b_busy", 48'(o_busy), 48'(1'b1));
        @(negedge i_clk);
        idle_in();
        check_val("b2b_vld1",  48'(o_dmac_lookup_vld), 48'(1'b1));
        check_val("b2b_rslt1", 48'(o_dmac_tx_port_rslt), 48'(4'b1000));
        @(negedge i_clk);
        drive(1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000);
        check_val("b2b_gap1", 48'(o_dmac_lookup_vld), 48'(1'b0));
        @(negedge i_clk);
        idle_in();
        check_val("b2b_gap2", 48'(o_dmac_lookup_vld), 48'(1'b0));
        @(negedge i_clk);
        check_val("b2b_vld2",  48'(o_dmac_lookup_vld), 48'(1'b1));
        check_val("b2b_rslt2", 48'(o_dmac_tx_port_rslt), 48'(4'b1000));
        check_val("b2b_drop",  48'(o_drop_cnt), 48'd1);
        @(negedge i_clk);
        check_quiet("b2b_end");

        // Aging: age 3 survives at most three sweeps, gone after four.
        req_chk("age_lrn", 1'b0, 12'h000, 48'h0, 1'b1, 12'h00A, MAC_G, 12'd5, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000);
        repeat (250) @(negedge i_clk);
        req_chk("age_live", 1'b1, 12'h00A, MAC_G, 1'b0, 12'h000, 48'h0, 12'd5, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
        repeat (250) @(negedge i_clk);
        req_chk("age_dead", 1'b1, 12'h00A, MAC_G, 1'b0, 12'h000, 48'h0, 12'd5, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
        req_chk("age_dead5", 1'b1, 12'h005, MAC_A, 1'b0, 12'h000, 48'h0, 12'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);

        // Relearn, then reset during a lookup: no strobe afterwards, table cleared.
        req_chk("rl_lrn", 1'b0, 12'h000, 48'h0, 1'b1, 12'h007, MAC_C, 12'd3, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000);
        @(negedge i_clk);
        drive(1'b1, 12'h007, MAC_C, 1'b0, 12'h000, 48'h0, 12'd3, 4'b0000);
        @(negedge i_clk);
        idle_in();
        i_rst = 1'b0;
        @(negedge i_clk);
        check_quiet("rstmid_in");
        check_val("rstmid_busy", 48'(o_busy), 48'(1'b0));
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check_quiet("rstmid_after");
        end
        check_val("rstmid_drop",   48'(o_drop_cnt), 48'd0);
        check_val("rstmid_lclash", 48'(o_learn_clash_cnt), 48'd0);
        req_chk("rst_clear", 1'b1, 12'h007, MAC_C, 1'b0, 12'h000, 48'h0, 12'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
